// File: rtl/commit_monitor.sv
// Commit-stream monitor: buffers every retired instruction in a FIFO and drains
// it to a valid/ready trace port, with cycle, retire and drop counters.
module commit_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             global_en,
    input  logic             commit,
    input  logic [31:0]      commit_pc,
    input  logic [31:0]      commit_inst,
    input  logic             commit_halt,
    input  logic             commit_reg_we,
    input  logic [4:0]       commit_reg_wa,
    input  logic [31:0]      commit_reg_wd,
    input  logic             commit_dmem_we,
    input  logic [31:0]      commit_dmem_wa,
    input  logic [31:0]      commit_dmem_wd,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_inst,
    output logic             trace_reg_we,
    output logic [4:0]       trace_reg_wa,
    output logic [31:0]      trace_reg_wd,
    output logic             trace_dmem_we,
    output logic [31:0]      trace_dmem_wa,
    output logic [31:0]      trace_dmem_wd,
    output logic             trace_halt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             halted,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
        logic        halt;
    } rec_t;

    rec_t             mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             halted_q, halted_d;
    logic             done_q, done_d;

    logic empty, full, pop, qual, push, drop;
    rec_t wr_rec, head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && trace_ready;
    assign qual  = commit && global_en && !halted_q;
    // A pop in the same edge frees the slot, so a full FIFO still accepts then.
    assign push  = qual && (!full || pop);
    assign drop  = qual && full && !pop;

    always_comb begin
        wr_rec         = '0;
        wr_rec.pc      = commit_pc;
        wr_rec.inst    = commit_inst;
        wr_rec.reg_we  = commit_reg_we && (commit_reg_wa != 5'd0);
        wr_rec.reg_wa  = commit_reg_wa;
        wr_rec.reg_wd  = commit_reg_wd;
        wr_rec.dmem_we = commit_dmem_we;
        wr_rec.dmem_wa = commit_dmem_wa;
        wr_rec.dmem_wd = commit_dmem_wd;
        wr_rec.halt    = commit_halt;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        drop_d    = drop_q;
        halted_d  = halted_q;
        done_d    = halted_q && empty;
        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            instret_d = instret_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (drop) begin
            drop_d = drop_q + CNT_W'(1);
        end
        if (global_en && !halted_q) begin
            cycle_d = cycle_q + CNT_W'(1);
        end
        // A halt stops capture even when its own record could not be stored.
        if (qual && commit_halt) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            drop_q    <= '0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            drop_q    <= drop_d;
            halted_q  <= halted_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
        end
    end

    // Storage is not reset, so the head is masked to zero while the FIFO is empty.
    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign trace_valid   = !empty;
    assign trace_pc      = head.pc;
    assign trace_inst    = head.inst;
    assign trace_reg_we  = head.reg_we;
    assign trace_reg_wa  = head.reg_wa;
    assign trace_reg_wd  = head.reg_wd;
    assign trace_dmem_we = head.dmem_we;
    assign trace_dmem_wa = head.dmem_wa;
    assign trace_dmem_wd = head.dmem_wd;
    assign trace_halt    = head.halt;
    assign cycle_cnt     = cycle_q;
    assign instret_cnt   = instret_q;
    assign drop_cnt      = drop_q;
    assign halted        = halted_q;
    assign done          = done_q;

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
- Consumer end of the CPU commit interface: samples every retired instruction (commit, commit_pc, commit_inst, register and dmem write info, halt) and buffers it in a FIFO.
- Drains records to an off-core trace port using a valid/ready handshake.
- Keeps cycle, retired-instruction and dropped-record counters, and raises done once halt has retired and the FIFO is empty.
- Sits beside CPU in the lab top level and in benches, in place of ad-hoc waveform inspection.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2
CNT_W, 32, width of cycle_cnt, instret_cnt and drop_cnt

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low (0 = reset)
global_en  input  1  count/capture enable, same meaning as on CPU
commit  input  1  an instruction retires this cycle
commit_pc  input  32  retiring PC
commit_inst  input  32  retiring instruction word
commit_halt  input  1  retiring instruction is halt
commit_reg_we  input  1  register write
commit_reg_wa  input  5  register write address
commit_reg_wd  input  32  register write data
commit_dmem_we  input  1  data memory write
commit_dmem_wa  input  32  data memory write address
commit_dmem_wd  input  32  data memory write data
trace_valid  output  1  head record available
trace_ready  input  1  sink accepts the head record
trace_pc  output  32  head record PC
trace_inst  output  32  head record instruction
trace_reg_we  output  1  head record register write (normalised)
trace_reg_wa  output  5  head record register address
trace_reg_wd  output  32  head record register data
trace_dmem_we  output  1  head record dmem write
trace_dmem_wa  output  32  head record dmem address
trace_dmem_wd  output  32  head record dmem data
trace_halt  output  1  head record is halt
cycle_cnt  output  CNT_W  enabled cycles before halt capture
instret_cnt  output  CNT_W  commits accepted into the FIFO
drop_cnt  output  CNT_W  commits lost because the FIFO was full
halted  output  1  sticky; a halt commit has been captured
done  output  1  halted and FIFO empty

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty; read and write pointers 0; all counters 0; halted=0; done=0; trace_valid=0. trace_* data outputs are don't-care when trace_valid=0 but must drive 0 out of reset. Reset mid-stream discards all buffered records.
- Capture: a push happens on a rising edge when commit=1, global_en=1, halted=0 and the FIFO is not full. Every commit_* field is written in that same cycle, so there is no extra sampling stage. If reg_we=1 and reg_wa=0, the stored reg_we is 0 (x0 writes are normalised away). The stored reg_wa and reg_wd are kept unchanged.
- Full: a qualifying commit while the FIFO is full and no pop occurs that cycle is dropped, and drop_cnt increments.
- Simultaneous push and pop when full: the push is accepted and nothing is dropped (the pop frees the slot in the same edge).
- Pop: happens when trace_valid=1 and trace_ready=1. The head is first-word-fall-through: trace_* reflect the head combinationally from registered storage, and trace_valid = not empty. The next record appears in the cycle after the pop.
- Latency: a commit at edge N is visible on trace_valid after edge N when the FIFO was empty.
- Simultaneous push and pop when empty: the pushed record becomes the head after the edge. Nothing is lost and count is unchanged.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB comparison. Wrap-around must be seamless.
- instret_cnt increments per accepted push. cycle_cnt increments on each edge with global_en=1 and halted=0. All counters wrap modulo 2^CNT_W silently.
- Halt: an accepted push with commit_halt=1 sets halted in the same edge. The halt record itself is stored and counted, and later commits are ignored (not counted as drops). If the halt commit itself is dropped because the FIFO is full, halted still sets.
- done = halted and empty, registered, so it asserts the cycle after the last pop completes.
- global_en=0: no capture, no cycle count, no drop count. Pops continue.

Test Plan:
- Reset then 3 commits (pc 0x0,0x4,0x8) with trace_ready=1 -> trace_pc sequence 0x0,0x4,0x8, each one cycle after its commit; instret_cnt=3, drop_cnt=0.
- trace_ready=0, 10 consecutive commits, DEPTH=8 -> 8 stored, drop_cnt=2; then ready=1 drains pc of commits 1..8 in order; trace_valid falls after the 8th pop.
- FIFO full with simultaneous commit and pop -> no drop, count stays 8, the new record appears last.
- Commit with reg_we=1, reg_wa=0, reg_wd=0x55 -> trace_reg_we=0 and trace_reg_wd=0x55. Commit with reg_wa=5 -> trace_reg_we=1.
- Halt commit at pc 0x1c, then 2 more commits, with ready=1 -> halted=1, instret_cnt includes halt, later commits ignored, drop_cnt unchanged, done=1 one cycle after the halt record pops, cycle_cnt frozen.
- rst pulse low for 3 ns between clock edges with 4 records buffered -> trace_valid=0 and all counters 0 immediately, with no clock edge required.
